// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions,
// controller states and a flag-packing helper.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_ZERO  = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic [4:0] pack_flags(input logic n, input logic z,
                                            input logic f, input logic l,
                                            input logic c);
    logic [4:0] v;
    v         = '0;
    v[FLAG_N] = n;
    v[FLAG_Z] = z;
    v[FLAG_F] = f;
    v[FLAG_L] = l;
    v[FLAG_C] = c;
    return v;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter: logical left, or arithmetic right
// when 'right' is set. One mux stage per shift-amount bit.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  input  logic             right,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stg [SHW+1];

  assign stg[0] = data;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int K = 1 << s;
    logic [WIDTH-1:0] sl;
    logic [WIDTH-1:0] sr;
    assign sl         = {stg[s][WIDTH-1-K:0], {K{1'b0}}};
    assign sr         = {{K{stg[s][WIDTH-1]}}, stg[s][WIDTH-1:K]};
    assign stg[s+1]   = amt[s] ? (right ? sr : sl) : stg[s];
  end

  assign out = stg[SHW];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage: single-cycle ops plus an iterative
// shift-add multiplier, with registered result/flags and a done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting start; non-multiply ops complete on the same edge
// ST_MUL  | shift-add multiply iterating, busy=1, starts ignored
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [4:0]       inst,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int MSB = WIDTH - 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] result_next;
  logic [4:0]       flags_next;
  logic             done_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]    count, count_next;
  logic             fwe_q, fwe_q_next;
  logic             lt_q, lt_q_next;

  logic [2:0]       opcode;
  logic             sub_mode;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] alu_val;
  logic             arith_op;
  logic [WIDTH-1:0] mul_step;

  assign opcode   = inst[2:0];
  // Compare always subtracts, whatever the modifier bit says.
  assign sub_mode = inst[3] | (opcode == OP_CMP);
  assign addend   = sub_mode ? ~reg2 : reg2;
  assign sum      = {1'b0, reg1} + {1'b0, addend} + {{WIDTH{1'b0}}, sub_mode};
  assign ovf      = sub_mode
                  ? (reg1[MSB] != reg2[MSB]) && (sum[MSB] != reg1[MSB])
                  : (reg1[MSB] == reg2[MSB]) && (sum[MSB] != reg1[MSB]);
  assign lt       = reg2 < reg1;
  assign arith_op = (opcode == OP_ADD) || (opcode == OP_CMP);
  assign mul_step = acc + (mplier[0] ? mcand : '0);

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .data  (reg1),
    .amt   (reg2[SHW-1:0]),
    .right (inst[3]),
    .out   (shifted)
  );

  always_comb begin
    alu_val = '0;
    case (opcode)
      OP_ADD, OP_CMP: alu_val = sum[WIDTH-1:0];
      OP_AND:         alu_val = reg1 & reg2;
      OP_OR:          alu_val = reg1 | reg2;
      OP_XOR:         alu_val = reg1 ^ reg2;
      OP_SHIFT:       alu_val = shifted;
      default:        alu_val = '0;
    endcase
  end

  always_comb begin
    state_next  = state;
    result_next = result;
    flags_next  = flags;
    done_next   = 1'b0;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    count_next  = count;
    fwe_q_next  = fwe_q;
    lt_q_next   = lt_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mcand_next  = reg1;
            mplier_next = reg2;
            fwe_q_next  = inst[4];
            lt_q_next   = lt;
            acc_next    = '0;
            count_next  = CW'(WIDTH);
            state_next  = ST_MUL;
          end else begin
            if (opcode != OP_CMP) result_next = alu_val;
            if (inst[4]) begin
              flags_next = pack_flags(alu_val[MSB], alu_val == '0,
                                      arith_op & ovf, lt,
                                      arith_op & sum[WIDTH]);
            end
            done_next = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_next    = mul_step;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count - 1'b1;
        // Last iteration: the final partial product goes straight to result.
        if (count == CW'(1)) begin
          result_next = mul_step;
          if (fwe_q) begin
            flags_next = pack_flags(mul_step[MSB], mul_step == '0,
                                    1'b0, lt_q, 1'b0);
          end
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      fwe_q  <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      result <= result_next;
      flags  <= flags_next;
      done   <= done_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      count  <= count_next;
      fwe_q  <= fwe_q_next;
      lt_q   <= lt_q_next;
    end
  end

  assign busy = (state == ST_MUL);

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It has a start/done handshake, registered result and flag outputs, and a barrel shifter. It also has an iterative shift-add multiplier and a flags-only compare. It sits in the CPU execute stage: the controller issues one operation, then samples `result`/`flags` on `done`.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a power of two, ≥ 4.
- `SHW`, default `$clog2(WIDTH)` (localparam): shift-amount width.

Ports:
- `clk` in, 1: the only clock. All state changes on its rising edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: operation request. Accepted only when `busy`=0.
- `reg1`, `reg2` in, WIDTH: operands. Sampled on the accepting edge only.
- `inst` in, 5: [2:0] opcode; [3] sub/right-shift modifier; [4] flag-write enable.
- `result` out, WIDTH: registered result, held until the next completion.
- `flags` out, 5: {N4, Z3, F2, L1, C0}, registered, held.
- `busy` out, 1: high while a multiply iterates.
- `done` out, 1: one-cycle pulse on the cycle after the result/flags update.

## Operation
- Opcodes:
  - 000: add, or subtract when inst[3]=1. Computed as `reg1 + (inst[3] ? ~reg2 : reg2) + inst[3]`, WIDTH+1 bits internally.
  - 001: AND.
  - 010: OR.
  - 011: XOR.
  - 100: shift by `reg2[SHW-1:0]`. inst[3]=0 is logical left; inst[3]=1 is arithmetic right.
  - 101: multiply, unsigned, low WIDTH bits of the product.
  - 110: compare. Performs the subtract, updates flags only; `result` is unchanged.
  - 111: `result` ← 0.
- Flags are written only when inst[4]=1, otherwise held:
  - C: adder carry-out (bit WIDTH) for 000/110; 0 for all other ops.
  - L: `reg2 < reg1`, unsigned, for every op.
  - F: signed overflow for 000/110. For add: operand signs equal and sum sign differs. For sub: operand signs differ and difference sign differs from reg1. 0 for all other ops.
  - Z: written value == 0. For 110, the subtract output.
  - N: MSB of the written value. For 110, the subtract output.
- State machine IDLE/MUL:
  - IDLE, start=1, opcode≠101: `result`/`flags` updated at that edge; `done`=1 in the next cycle; stay in IDLE.
  - IDLE, start=1, opcode=101: latch multiplicand (reg1), multiplier (reg2) and inst[4]. Clear the accumulator, load counter=WIDTH, go to MUL, `busy`=1.
  - MUL, each edge: if multiplier LSB=1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter -= 1.
  - MUL, edge where counter goes 1→0: write `result`=acc (final add included). Flags: Z/N from it, C=F=0, L from the latched operands. Set `done`, return to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- Reset clears everything, including mid-multiply (operation aborted): `result`=0, `flags`=0, `busy`=0, `done`=0, state IDLE, counter=0.

## Timing
- Non-multiply ops:
  - Latency 1: start sampled at edge E, outputs valid and `done`=1 in cycle E+1.
  - Back-to-back issue every cycle is legal.
- Multiply:
  - Start at edge E; `busy` high from E+1 through the cycle ending at edge E+WIDTH.
  - Result written at edge E+WIDTH; `done`=1 in the cycle after E+WIDTH, with `busy`=0 in that cycle.
  - A new start in that `done` cycle is accepted.
- `done` is exactly one cycle wide. It is never asserted for an ignored start.
- No combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg`: opcode constants (OP_ADD…OP_ZERO), flag bit-index constants (FLAG_C…FLAG_N), state enum.
- One sub-module: `alu_shifter` (combinational barrel shifter, WIDTH-parametrised, left-logical / right-arithmetic).
- Adder, logic ops, flag generation and the FSM stay in `alu_mc`.

## Test plan
All values at WIDTH=16.
- Add 0xFFFF + 0x0001, inst=5'b10000 → result 0x0000, flags C=1 Z=1 N=0 F=0 L=1; `done` one cycle after start.
- Sub 0x8000 − 0x0001, inst=5'b11000 → result 0x7FFF, F=1, N=0, Z=0, L=1, C=1. Then compare 0x0005 vs 0x0005 (inst=5'b10110) → Z=1, `result` still 0x7FFF.
- Multiply 0x0012 × 0x0034, inst=5'b10101 → result 0x03A8.
  - `busy` high exactly 16 cycles; `done` on the 17th cycle after the start edge.
  - Extra start pulses during `busy` are ignored; no extra `done`.
- Shifts:
  - 0x00F1 << 4 (inst=5'b10100, reg2=4) → 0x0F10.
  - 0x8001 >>> 1 (inst=5'b11100, reg2=1) → 0xC000, N=1.
- Reset asserted during cycle 5 of a multiply → next cycle `busy`=0, `done`=0, `result`=0, `flags`=0. A subsequent add 3+4 → 0x0007 with normal 1-cycle latency.
- Add 0x0001 + 0xFFFF with inst[4]=0 after flags=0 → result 0x0000, flags stay 0.
